// File: rtl/sync_decode_pkg.sv
// Shared types and constants for the lighthouse sync pulse decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default geometry (CW/BASE/STEP/FILT),
// the code-window threshold helper and the bit positions of {skip, data, axis}.
package sync_decode_pkg;

    typedef enum logic [1:0] {
        SD_IDLE    = 2'd0,
        SD_MEASURE = 2'd1,
        SD_DECIDE  = 2'd2
    } sd_state_e;

    localparam int SD_CW   = 13;    // width counter bits
    localparam int SD_BASE = 3125;  // code-0 width, 62.5 us @ 50 MHz
    localparam int SD_STEP = 521;   // per-code increment, 10.42 us @ 50 MHz
    localparam int SD_FILT = 4;     // stability clocks, legal 2..15

    // Positions inside code = {skip, data, axis}
    localparam int AXIS_BIT = 0;
    localparam int DATA_BIT = 1;
    localparam int SKIP_BIT = 2;

    // Lower edge of the window for code k: windows are centred on
    // BASE + k*STEP, so each starts half a step below the nominal width.
    function automatic int sd_threshold(int base, int step, int k);
        return base - step / 2 + k * step;
    endfunction

endpackage

// File: rtl/sync_pulse_decoder_if.sv
// Signal bundle between the optical front end, the decoder and its consumers.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
//
// master: the decoder (consumes sync_in, drives everything else).
// slave : the environment (drives sync_in, observes the decoded results).
interface sync_pulse_decoder_if
    import sync_decode_pkg::*;
#(
    parameter int CW = SD_CW
);
    logic          sync_in;     // raw combined sensor level, async to clk
    logic          sync_clean;  // synchronized, filtered level
    logic          valid;       // accepted flash strobe
    logic          reject;      // out-of-range flash strobe
    logic [2:0]    code;        // {skip, data, axis}
    logic          axis;
    logic          data;
    logic          skip;
    logic [CW-1:0] width;       // high time of last measured flash
    logic          sweep_axis;  // axis of last accepted non-skip flash

    modport master (
        input  sync_in,
        output sync_clean, valid, reject, code, axis, data, skip, width, sweep_axis
    );

    modport slave (
        output sync_in,
        input  sync_clean, valid, reject, code, axis, data, skip, width, sweep_axis
    );

endinterface

// File: rtl/glitch_filter.sv
// 2-FF synchronizer followed by a stability filter on the optical sync level.
// Latency: dout follows din by 2+FILT clocks on both edges (high time preserved).
// Backpressure: none; free-running level path.
//
// Ports: clk, rst (async active-high), din (async level), dout (clean level).
// FILT must lie in 2..15 so the 4-bit stability counter can hold FILT-1.
module glitch_filter
    import sync_decode_pkg::*;
#(
    parameter int FILT = SD_FILT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] CNT_LAST = 4'(FILT - 1);

    logic       meta_q,  meta_d;
    logic       sync_q,  sync_d;
    logic       clean_q, clean_d;
    logic [3:0] cnt_q,   cnt_d;

    // The counter runs only while the synchronized level disagrees with the
    // filtered one; any return to agreement restarts the count, so only a
    // level that persists FILT clocks gets through.
    always_comb begin
        meta_d  = din;
        sync_d  = meta_q;
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = clean_q;

endmodule

// File: rtl/sync_pulse_decoder.sv
// Measures each clean sync flash and classifies its width into {skip, data, axis}.
// Latency: valid/reject pulse on the 2nd clock edge after sync_clean falls.
// Backpressure: none; strobes are single-cycle, results held until next update.
//
// Ports: clk, rst (async active-high), bus (master modport: sync_in in,
// sync_clean/valid/reject/code/axis/data/skip/width/sweep_axis out).
module sync_pulse_decoder
    import sync_decode_pkg::*;
#(
    parameter int CW   = SD_CW,
    parameter int BASE = SD_BASE,
    parameter int STEP = SD_STEP,
    parameter int FILT = SD_FILT
) (
    input  logic                    clk,
    input  logic                    rst,
    sync_pulse_decoder_if.master    bus
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    // Saturated widths must land at or above LIM_HI to be rejected; true for
    // the default geometry (L8 = 7033 < 8191).
    localparam logic [CW-1:0] LIM_LO  = CW'(sd_threshold(BASE, STEP, 0));
    localparam logic [CW-1:0] LIM_HI  = CW'(sd_threshold(BASE, STEP, 8));

    logic sync_clean;

    glitch_filter #(
        .FILT (FILT)
    ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.sync_in),
        .dout (sync_clean)
    );

    sd_state_e     state_q,  state_d;
    logic [CW-1:0] count_q,  count_d;
    logic [CW-1:0] width_q,  width_d;
    logic [2:0]    code_q,   code_d;
    logic          sweep_q,  sweep_d;
    logic          valid_q,  valid_d;
    logic          reject_q, reject_d;

    logic [2:0]    k_code;
    logic          in_range;

    // Window index: the highest k whose lower edge the count has reached.
    always_comb begin
        k_code = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (count_q >= CW'(sd_threshold(BASE, STEP, k))) begin
                k_code = 3'(k);
            end
        end
        in_range = (count_q >= LIM_LO) && (count_q < LIM_HI);
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        width_d  = width_q;
        code_d   = code_q;
        sweep_d  = sweep_q;
        valid_d  = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            SD_IDLE: begin
                if (sync_clean) begin
                    state_d = SD_MEASURE;
                    count_d = CW'(1);
                end
            end
            SD_MEASURE: begin
                if (sync_clean) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    state_d = SD_DECIDE;
                end
            end
            SD_DECIDE: begin
                // sync_clean cannot rise here: the filter needs >= 2 clocks
                // of new level, so the next flash is seen from IDLE.
                state_d = SD_IDLE;
                width_d = count_q;
                if (in_range) begin
                    valid_d = 1'b1;
                    code_d  = k_code;
                    // Skip flashes carry no sweep, so they don't retarget it.
                    if (!k_code[SKIP_BIT]) begin
                        sweep_d = k_code[AXIS_BIT];
                    end
                end else begin
                    reject_d = 1'b1;
                end
            end
            default: begin
                state_d = SD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SD_IDLE;
            count_q  <= '0;
            width_q  <= '0;
            code_q   <= '0;
            sweep_q  <= 1'b0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            width_q  <= width_d;
            code_q   <= code_d;
            sweep_q  <= sweep_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
        end
    end

    assign bus.sync_clean = sync_clean;
    assign bus.valid      = valid_q;
    assign bus.reject     = reject_q;
    assign bus.code       = code_q;
    assign bus.axis       = code_q[AXIS_BIT];
    assign bus.data       = code_q[DATA_BIT];
    assign bus.skip       = code_q[SKIP_BIT];
    assign bus.width      = width_q;
    assign bus.sweep_axis = sweep_q;

endmodule

// File: tb/tb_sync_pulse_decoder.sv
// Self-checking bench for sync_pulse_decoder: directed width table,
// reset-mid-pulse sequence, then random pulses against a width-rule model.
module tb_sync_pulse_decoder;

    localparam int CW     = 13;
    localparam int BASE   = 3125;
    localparam int STEP   = 521;
    localparam int FILT   = 4;
    localparam int M_L0   = BASE - STEP / 2;     // 2865
    localparam int M_L8   = M_L0 + 8 * STEP;     // 7033
    localparam int SAT    = (1 << CW) - 1;       // 8191
    localparam int LO_GAP = FILT + 10;

    logic clk = 1'b0;
    logic rst;

    sync_pulse_decoder_if #(.CW(CW)) bus ();

    sync_pulse_decoder #(
        .CW   (CW),
        .BASE (BASE),
        .STEP (STEP),
        .FILT (FILT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Observations gathered over one pulse
    int n_valid, n_reject, n_both, strobe_at, clean_cnt, clean_first, code_at_strobe;

    // Reference model state
    int m_code, m_width, m_sweep;

    typedef struct {
        int hi;
        int v;
        int r;
        int code;
        int width;
        int sweep;
    } vec_t;

    vec_t tv [12];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge. Drives sync_in high for hi clocks, low for LO_GAP,
    // and records what the DUT does, one sample per negedge.
    task automatic run_pulse(input int hi);
        n_valid = 0; n_reject = 0; n_both = 0; clean_cnt = 0;
        strobe_at = -1; clean_first = -1; code_at_strobe = -1;
        bus.sync_in = 1'b1;
        for (int n = 1; n <= hi + LO_GAP; n++) begin
            @(negedge clk);
            if (bus.sync_clean) begin
                clean_cnt++;
                if (clean_first < 0) clean_first = n;
            end
            if (bus.valid)  n_valid++;
            if (bus.reject) n_reject++;
            if (bus.valid && bus.reject) n_both++;
            if ((bus.valid || bus.reject) && strobe_at < 0) begin
                strobe_at      = n - hi;
                code_at_strobe = int'(bus.code);
            end
            if (n == hi) bus.sync_in = 1'b0;
        end
    endtask

    task automatic check_pulse(input string tag, input int hi, input int ev, input int er,
                               input int ecode, input int ewidth, input int esweep);
        check({tag, ".valid_cnt"},  n_valid,  ev);
        check({tag, ".reject_cnt"}, n_reject, er);
        check({tag, ".both"},       n_both,   0);
        if (ev != 0 || er != 0) check({tag, ".strobe_lat"}, strobe_at, 4 + FILT);
        if (ev != 0) check({tag, ".code_at_strobe"}, code_at_strobe, ecode);
        check({tag, ".clean_len"}, clean_cnt, (hi >= FILT) ? hi : 0);
        if (hi >= FILT) check({tag, ".clean_lag"}, clean_first, 2 + FILT);
        check({tag, ".code"},   int'(bus.code), ecode);
        check({tag, ".fields"}, int'({bus.skip, bus.data, bus.axis}), ecode);
        check({tag, ".width"},  int'(bus.width), ewidth);
        check({tag, ".sweep"},  int'(bus.sweep_axis), esweep);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sync_clean"}, int'(bus.sync_clean), 0);
        check({tag, ".valid"},      int'(bus.valid), 0);
        check({tag, ".reject"},     int'(bus.reject), 0);
        check({tag, ".code"},       int'(bus.code), 0);
        check({tag, ".fields"},     int'({bus.skip, bus.data, bus.axis}), 0);
        check({tag, ".width"},      int'(bus.width), 0);
        check({tag, ".sweep"},      int'(bus.sweep_axis), 0);
    endtask

    // Width rules: code k covers [L0 + k*STEP, L0 + (k+1)*STEP); anything
    // outside [L0, L8) (including a saturated count) is rejected.
    task automatic model_pulse(input int hi, output int ev, output int er);
        int w;
        ev = 0;
        er = 0;
        if (hi >= FILT) begin
            w = (hi > SAT) ? SAT : hi;
            m_width = w;
            if (w < M_L0 || w >= M_L8) begin
                er = 1;
            end else begin
                ev = 1;
                m_code = (w - M_L0) / STEP;
                if (m_code < 4) m_sweep = m_code % 2;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        int ev, er, hi, rem;

        //             hi    v  r  code width sweep
        tv[0]  = '{ 3125, 1, 0, 0, 3125, 0 };
        tv[1]  = '{ 3386, 1, 0, 1, 3386, 1 };
        tv[2]  = '{ 5730, 1, 0, 5, 5730, 1 };  // skip=1: sweep_axis untouched
        tv[3]  = '{ 2864, 0, 1, 5, 2864, 1 };
        tv[4]  = '{ 2865, 1, 0, 0, 2865, 0 };
        tv[5]  = '{ 3385, 1, 0, 0, 3385, 0 };
        tv[6]  = '{ 7032, 1, 0, 7, 7032, 0 };
        tv[7]  = '{ 7033, 0, 1, 7, 7033, 0 };
        tv[8]  = '{  200, 0, 1, 7,  200, 0 };  // sweep-width pulse
        tv[9]  = '{    3, 0, 0, 7,  200, 0 };  // glitch below FILT
        tv[10] = '{ 9000, 0, 1, 7, 8191, 0 };  // saturates, no wrap
        tv[11] = '{ 4428, 1, 0, 3, 4428, 1 };

        rst = 1'b1;
        bus.sync_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_pulse(tv[i].hi);
            check_pulse($sformatf("vec%0d_w%0d", i, tv[i].hi), tv[i].hi,
                        tv[i].v, tv[i].r, tv[i].code, tv[i].width, tv[i].sweep);
        end

        // Reset 1000 clocks into a 3125-clock flash, held for 3 clocks.
        bus.sync_in = 1'b1;
        repeat (1000) @(negedge clk);
        check("mid_rst.pre_clean", int'(bus.sync_clean), 1);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst.async");
        ev = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.valid || bus.reject) ev++;
        end
        check("mid_rst.strobes_in_reset", ev, 0);
        rst = 1'b0;
        // Input is still high: the remainder is measured as a fresh flash,
        // which is too short and so rejected; the cut-off head yields nothing.
        rem = 3125 - 1000 - 3;
        run_pulse(rem);
        check_pulse("mid_rst.tail", rem, 0, 1, 0, rem, 0);
        run_pulse(3646);
        check_pulse("post_rst.w3646", 3646, 1, 0, 1, 3646, 1);

        m_code  = 1;
        m_width = 3646;
        m_sweep = 1;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) hi = int'($urandom_range(1, 400));
            else                           hi = int'($urandom_range(2700, 7200));
            model_pulse(hi, ev, er);
            run_pulse(hi);
            check_pulse($sformatf("rand%0d_w%0d", i, hi), hi, ev, er, m_code, m_width, m_sweep);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_pulse_decoder.md
# sync_pulse_decoder

Conditions the combined all-sensor optical signal and classifies each lighthouse sync flash by its width into the three encoded bits (axis, data, skip). Sits directly upstream of the lock timer and the per-sensor center capture. It supplies a glitch-free sync level for lock acquisition, plus a decoded axis that replaces free-running sweep toggling. Rejects sweep-width pulses and out-of-range flashes.

## Interface
- CW, 13: width counter bits; saturates at 2^CW-1.
- BASE, 3125: nominal code-0 width in clocks (62.5 µs @ 50 MHz).
- STEP, 521: width increment per code step (10.42 µs @ 50 MHz).
- FILT, 4: clocks the synchronized input must be stable before `sync_clean` follows; legal range 2..15.
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- sync_in  in  1  active-high AND of inverted sensor inputs; asynchronous to clk.
- sync_clean  out  1  synchronized, glitch-filtered level; drives lock timer `sync_pulse`.
- valid  out  1  one-cycle strobe: accepted flash decoded.
- reject  out  1  one-cycle strobe: flash measured but out of range.
- code  out  3  {skip, data, axis}; held until next `valid`.
- axis, data, skip  out  1 each  bit fields of `code`.
- width  out  CW  measured high time of last flash, accepted or rejected.
- sweep_axis  out  1  axis of last accepted flash with skip=0.

## Operation
- Input path: 2-FF synchronizer, then stability filter. `sync_clean` takes the synchronized value after it has held for FILT consecutive clocks. Both edges are delayed equally, so the high time is preserved.
- FSM states: IDLE, MEASURE, DECIDE.
  - IDLE: on `sync_clean`=1, go to MEASURE with count=1.
  - MEASURE: while high, count+1, saturating at 2^CW-1. When low, go to DECIDE.
  - DECIDE: classify `count`, then go to IDLE unconditionally.
- Classification: L0 = BASE - STEP/2 (integer division); Lk = L0 + k·STEP.
  - code = k when Lk ≤ count < Lk+1, for k=0..7.
  - count < L0 or count ≥ L8 → reject. This covers saturation.
  - Defaults give L0..L8 = 2865, 3386, 3907, 4428, 4949, 5470, 5991, 6512, 7033.
  - Comparisons are unsigned CW-bit, with thresholds precomputed as constants.
- On accept: update `code`/`axis`/`data`/`skip`/`width`, pulse `valid`. If skip=0, also set `sweep_axis`=axis.
- On reject: update `width` only and pulse `reject`. `code` and `sweep_axis` are unchanged.
- `valid` and `reject` are never high in the same cycle.

## Timing
- Reset: every output 0; FSM in IDLE; synchronizer and filter cleared to 0.
- Reset asserted mid-pulse: outputs clear immediately, and no strobe is generated for that pulse. After reset releases, a still-high input first produces a rising `sync_clean` 2+FILT clocks later, and is measured from there.
- Latency:
  - `sync_clean` lags `sync_in` by 2+FILT clocks on each edge.
  - `valid`/`reject` rise on the 2nd clock edge after `sync_clean` falls.
  - The decoded outputs change on the same edge as the strobe.
- A pulse shorter than FILT synchronized clocks never reaches `sync_clean` and produces no strobe.
- FILT ≥ 2 guarantees `sync_clean` cannot rise during DECIDE, so no edge is lost.

## Structure
- Package `sync_decode_pkg`:
  - FSM state enum.
  - Default BASE/STEP/CW.
  - Constant function giving threshold Lk from (BASE, STEP, k).
  - Field indices for {skip, data, axis}.
- Sub-module `glitch_filter` holds the 2-FF synchronizer and the FILT stability counter, parameterized by FILT. The FSM, classifier and output registers live in `sync_pulse_decoder`.

## Test plan
- Stable high of 3125 clocks → `sync_clean` high exactly 3125 clocks; `valid` 2 clocks after its fall; code=0, width=3125, sweep_axis=0.
- High of 5730 clocks (code 5) → valid; skip=1, data=0, axis=1. After a prior code-1 flash, sweep_axis stays 1 because skip=1 leaves it unchanged.
- Threshold widths:
  - 2864 → reject.
  - 2865 → code 0.
  - 3385 → code 0.
  - 3386 → code 1.
  - 7032 → code 7.
  - 7033 → reject.
- Short pulses:
  - 200-clock sweep pulse → reject with width=200; code unchanged.
  - 3-clock glitch with FILT=4 → `sync_clean` stays 0; no strobe.
- High of 9000 clocks → width saturates at 8191; reject; no wrap to a small value.
- rst pulsed at clock 1000 of a 3125-clock pulse → all outputs 0 asynchronously; no strobe for the truncated pulse. The next 3646-clock pulse decodes code 1 and sets sweep_axis=1.
